id_ex_stage: RTL and testbench

ID/EX pipeline register for the five-stage MIPS pipeline. It integrates load-use hazard detection, bubble insertion, branch flush and a WB-to-ID register write-through. It captures decoded ID-stage state on each clock and presents it to EX. Its ID_EX_Rs, ID_EX_Rt and control outputs are what the forwarding unit and ALU consume. It also drives the Stall signal that freezes PC and IF/ID.

---
 rtl/id_ex_stage_pkg.sv | 56 +++++
 rtl/id_ex_stage_load_use_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: widths, ALU op
// encoding, the packed EX-stage field bundle and its all-zero bubble.
package id_ex_stage_pkg;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  // Register $0 is hardwired to zero, so it never creates a dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Every field the EX stage sees, in one packed bundle.
  typedef struct packed {
    logic               valid;
    logic               reg_wr;
    logic               mem_rd;
    logic               mem_wr;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   reg_dst;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [DATA_W-1:0]  bus_a;
    logic [DATA_W-1:0]  bus_b;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
  } id_ex_t;

  // A bubble zeroes indices too, so forwarding can never match it.
  localparam id_ex_t BUBBLE = '0;

  // True when the register being written back this cycle is the one ID reads.
  function automatic logic wb_hits(input logic             wb_wr,
                                   input logic [REG_W-1:0] wb_dst,
                                   input logic [REG_W-1:0] src);
    return wb_wr && (wb_dst != ZERO_REG) && (wb_dst == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination is read
// by the instruction currently in ID. Shared with the hazard unit.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] ex_reg_dst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  output logic             lu
);

  logic is_load;
  logic rs_dep;
  logic rt_dep;

  // Only a real load to a non-zero register can produce a hazard.
  always_comb begin
    is_load = ex_valid && ex_mem_rd && (ex_reg_dst != ZERO_REG);
    rs_dep  = uses_rs && (ex_reg_dst == id_rs);
    rt_dep  = uses_rt && (ex_reg_dst == id_rt);
    lu      = is_load && (rs_dep || rt_dep);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// WB-to-ID write-through and a saturating count of load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               Hold,
  input  logic               Flush,
  input  logic               ID_Valid,
  input  logic [REG_W-1:0]   IF_ID_Rs,
  input  logic [REG_W-1:0]   IF_ID_Rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               ID_RegWr,
  input  logic               ID_MemRd,
  input  logic               ID_MemWr,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [REG_W-1:0]   ID_RegDst,
  input  logic [DATA_W-1:0]  ID_BusA,
  input  logic [DATA_W-1:0]  ID_BusB,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PC,
  input  logic               MEM_WB_RegWr,
  input  logic [REG_W-1:0]   MEM_WB_RegDst,
  input  logic [DATA_W-1:0]  WB_Data,
  output logic               ID_EX_Valid,
  output logic               ID_EX_RegWr,
  output logic               ID_EX_MemRd,
  output logic               ID_EX_MemWr,
  output logic               ID_EX_MemToReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [REG_W-1:0]   ID_EX_RegDst,
  output logic [REG_W-1:0]   ID_EX_Rs,
  output logic [REG_W-1:0]   ID_EX_Rt,
  output logic [DATA_W-1:0]  ID_EX_BusA,
  output logic [DATA_W-1:0]  ID_EX_BusB,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic [DATA_W-1:0]  ID_EX_PC,
  output logic               Stall,
  output logic [CNT_W-1:0]   StallCount
);

  id_ex_t           ex_q;
  id_ex_t           capture;
  logic             lu;
  logic [CNT_W-1:0] stall_cnt;

  load_use_detect u_load_use_detect (
    .ex_valid   (ex_q.valid),
    .ex_mem_rd  (ex_q.mem_rd),
    .ex_reg_dst (ex_q.reg_dst),
    .id_rs      (IF_ID_Rs),
    .id_rt      (IF_ID_Rt),
    .uses_rs    (ID_UsesRs),
    .uses_rt    (ID_UsesRt),
    .lu         (lu)
  );

  // A flush already kills the ID instruction, so stalling on top of it is pointless.
  assign Stall = lu && !Flush;

  // Build the next EX bundle from ID, substituting WB data written this same cycle.
  always_comb begin
    capture            = BUBBLE;
    capture.valid      = ID_Valid;
    capture.reg_wr     = ID_RegWr;
    capture.mem_rd     = ID_MemRd;
    capture.mem_wr     = ID_MemWr;
    capture.mem_to_reg = ID_MemToReg;
    capture.alu_src    = ID_ALUSrc;
    capture.alu_op     = ID_ALUOp;
    capture.reg_dst    = ID_RegDst;
    capture.rs         = IF_ID_Rs;
    capture.rt         = IF_ID_Rt;
    capture.bus_a      = wb_hits(MEM_WB_RegWr, MEM_WB_RegDst, IF_ID_Rs) ? WB_Data : ID_BusA;
    capture.bus_b      = wb_hits(MEM_WB_RegWr, MEM_WB_RegDst, IF_ID_Rt) ? WB_Data : ID_BusB;
    capture.imm        = ID_Imm;
    capture.pc         = ID_PC;
  end

  // Priority update: hold freezes everything, flush and load-use insert bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= BUBBLE;
      stall_cnt <= '0;
    end else if (Hold) begin
      ex_q      <= ex_q;
      stall_cnt <= stall_cnt;
    end else if (Flush) begin
      ex_q      <= BUBBLE;
    end else if (lu) begin
      ex_q      <= BUBBLE;
      if (stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      ex_q      <= capture;
    end
  end

  assign ID_EX_Valid    = ex_q.valid;
  assign ID_EX_RegWr    = ex_q.reg_wr;
  assign ID_EX_MemRd    = ex_q.mem_rd;
  assign ID_EX_MemWr    = ex_q.mem_wr;
  assign ID_EX_MemToReg = ex_q.mem_to_reg;
  assign ID_EX_ALUSrc   = ex_q.alu_src;
  assign ID_EX_ALUOp    = ex_q.alu_op;
  assign ID_EX_RegDst   = ex_q.reg_dst;
  assign ID_EX_Rs       = ex_q.rs;
  assign ID_EX_Rt       = ex_q.rt;
  assign ID_EX_BusA     = ex_q.bus_a;
  assign ID_EX_BusB     = ex_q.bus_b;
  assign ID_EX_Imm      = ex_q.imm;
  assign ID_EX_PC       = ex_q.pc;
  assign StallCount     = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the pipeline register.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               Hold, Flush, ID_Valid;
  logic [REG_W-1:0]   IF_ID_Rs, IF_ID_Rt;
  logic               ID_UsesRs, ID_UsesRt;
  logic               ID_RegWr, ID_MemRd, ID_MemWr, ID_MemToReg, ID_ALUSrc;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic [REG_W-1:0]   ID_RegDst;
  logic [DATA_W-1:0]  ID_BusA, ID_BusB, ID_Imm, ID_PC;
  logic               MEM_WB_RegWr;
  logic [REG_W-1:0]   MEM_WB_RegDst;
  logic [DATA_W-1:0]  WB_Data;
  logic               ID_EX_Valid, ID_EX_RegWr, ID_EX_MemRd, ID_EX_MemWr;
  logic               ID_EX_MemToReg, ID_EX_ALUSrc;
  logic [ALUOP_W-1:0] ID_EX_ALUOp;
  logic [REG_W-1:0]   ID_EX_RegDst, ID_EX_Rs, ID_EX_Rt;
  logic [DATA_W-1:0]  ID_EX_BusA, ID_EX_BusB, ID_EX_Imm, ID_EX_PC;
  logic               Stall;
  logic [CNT_W-1:0]   StallCount;

  // Expected EX-stage contents, held in the bench's own layout.
  typedef struct packed {
    logic        valid, regWr, memRd, memWr, memToReg, aluSrc;
    logic [3:0]  aluOp;
    logic [4:0]  regDst, rs, rt;
    logic [31:0] busA, busB, imm, pc;
  } modelRegs_t;

  modelRegs_t       m;
  logic [CNT_W-1:0] mCount;
  int               checks = 0;
  int               errors = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .Hold(Hold), .Flush(Flush), .ID_Valid(ID_Valid),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_RegWr(ID_RegWr), .ID_MemRd(ID_MemRd), .ID_MemWr(ID_MemWr),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
    .ID_RegDst(ID_RegDst), .ID_BusA(ID_BusA), .ID_BusB(ID_BusB), .ID_Imm(ID_Imm),
    .ID_PC(ID_PC), .MEM_WB_RegWr(MEM_WB_RegWr), .MEM_WB_RegDst(MEM_WB_RegDst),
    .WB_Data(WB_Data), .ID_EX_Valid(ID_EX_Valid), .ID_EX_RegWr(ID_EX_RegWr),
    .ID_EX_MemRd(ID_EX_MemRd), .ID_EX_MemWr(ID_EX_MemWr), .ID_EX_MemToReg(ID_EX_MemToReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_BusA(ID_EX_BusA),
    .ID_EX_BusB(ID_EX_BusB), .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
    .Stall(Stall), .StallCount(StallCount)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // A load in EX whose non-zero destination is read by the ID instruction.
  function automatic logic modelLoadUse();
    return m.valid && m.memRd && (m.regDst != 5'd0) &&
           ((ID_UsesRs && m.regDst == IF_ID_Rs) || (ID_UsesRt && m.regDst == IF_ID_Rt));
  endfunction

  function automatic logic [152:0] dutVec();
    return {ID_EX_Valid, ID_EX_RegWr, ID_EX_MemRd, ID_EX_MemWr, ID_EX_MemToReg,
            ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_RegDst, ID_EX_Rs, ID_EX_Rt,
            ID_EX_BusA, ID_EX_BusB, ID_EX_Imm, ID_EX_PC};
  endfunction

  // What one rising edge does to the expected state.
  task automatic modelEdge();
    logic lu;
    lu = modelLoadUse();
    if (Hold) begin
      m = m;
    end else if (Flush) begin
      m = '0;
    end else if (lu) begin
      m = '0;
      if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
    end else begin
      m.valid    = ID_Valid;
      m.regWr    = ID_RegWr;
      m.memRd    = ID_MemRd;
      m.memWr    = ID_MemWr;
      m.memToReg = ID_MemToReg;
      m.aluSrc   = ID_ALUSrc;
      m.aluOp    = ID_ALUOp;
      m.regDst   = ID_RegDst;
      m.rs       = IF_ID_Rs;
      m.rt       = IF_ID_Rt;
      m.busA     = (MEM_WB_RegWr && MEM_WB_RegDst != 5'd0 && MEM_WB_RegDst == IF_ID_Rs) ? WB_Data : ID_BusA;
      m.busB     = (MEM_WB_RegWr && MEM_WB_RegDst != 5'd0 && MEM_WB_RegDst == IF_ID_Rt) ? WB_Data : ID_BusB;
      m.imm      = ID_Imm;
      m.pc       = ID_PC;
    end
  endtask

  task automatic checkStall(input string tag);
    logic exp;
    exp = modelLoadUse() && !Flush;
    checks++;
    assert (Stall === exp) else begin
      errors++;
      $error("[TB] FAIL %s Stall observed=%0b expected=%0b", tag, Stall, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (dutVec() === m) else begin
      errors++;
      $error("[TB] FAIL %s regs observed=%h expected=%h", tag, dutVec(), m);
    end
    checks++;
    assert (StallCount === mCount) else begin
      errors++;
      $error("[TB] FAIL %s StallCount observed=%0d expected=%0d", tag, StallCount, mCount);
    end
  endtask

  task automatic expectVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic stepCycle(input string tag);
    #1 checkStall(tag);
    @(posedge clk);
    if (reset) modelEdge();
    #1 checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    Hold = 0; Flush = 0; ID_Valid = 0;
    IF_ID_Rs = '0; IF_ID_Rt = '0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_RegWr = 0; ID_MemRd = 0; ID_MemWr = 0; ID_MemToReg = 0; ID_ALUSrc = 0;
    ID_ALUOp = '0; ID_RegDst = '0; ID_BusA = '0; ID_BusB = '0; ID_Imm = '0; ID_PC = '0;
    MEM_WB_RegWr = 0; MEM_WB_RegDst = '0; WB_Data = '0;
  endtask

  // Random traffic biased toward small register numbers so hazards are common.
  task automatic applyStimulus();
    Hold          = ($urandom_range(0, 9) == 0);
    Flush         = ($urandom_range(0, 7) == 0);
    ID_Valid      = ($urandom_range(0, 5) != 0);
    IF_ID_Rs      = REG_W'($urandom_range(0, 3));
    IF_ID_Rt      = REG_W'($urandom_range(0, 3));
    ID_UsesRs     = 1'($urandom_range(0, 1));
    ID_UsesRt     = 1'($urandom_range(0, 1));
    ID_RegWr      = 1'($urandom_range(0, 1));
    ID_MemRd      = 1'($urandom_range(0, 1));
    ID_MemWr      = 1'($urandom_range(0, 1));
    ID_MemToReg   = 1'($urandom_range(0, 1));
    ID_ALUSrc     = 1'($urandom_range(0, 1));
    ID_ALUOp      = ALUOP_W'($urandom_range(0, 15));
    ID_RegDst     = REG_W'($urandom_range(0, 3));
    ID_BusA       = $urandom();
    ID_BusB       = $urandom();
    ID_Imm        = $urandom();
    ID_PC         = $urandom();
    MEM_WB_RegWr  = 1'($urandom_range(0, 1));
    MEM_WB_RegDst = REG_W'($urandom_range(0, 3));
    WB_Data       = $urandom();
  endtask

  initial begin
    clearInputs();
    reset = 0;
    m = '0;
    mCount = '0;
    #2 checkOutput("reset_state");
    checkStall("reset_stall");
    @(negedge clk);
    reset = 1;

    // Load r8, then an add reading r8 must wait exactly one bubble.
    ID_Valid = 1; ID_MemRd = 1; ID_RegWr = 1; ID_MemToReg = 1; ID_ALUSrc = 1;
    ID_RegDst = 5'd8; IF_ID_Rs = 5'd2; ID_UsesRs = 1; ID_Imm = 32'h10; ID_PC = 32'h100;
    stepCycle("load_capture");
    ID_MemRd = 0; ID_MemToReg = 0; ID_ALUSrc = 0; ID_RegDst = 5'd9;
    IF_ID_Rs = 5'd8; IF_ID_Rt = 5'd3; ID_UsesRt = 1; ID_BusA = 32'h11; ID_BusB = 32'h22;
    ID_PC = 32'h104;
    #1 expectVal("lu_stall", 32'(Stall), 32'd1);
    stepCycle("lu_bubble");
    expectVal("bubble_valid", 32'(ID_EX_Valid), 32'd0);
    expectVal("bubble_regwr", 32'(ID_EX_RegWr), 32'd0);
    expectVal("bubble_count", 32'(StallCount), 32'd1);
    #1 expectVal("lu_cleared", 32'(Stall), 32'd0);
    stepCycle("add_capture");
    expectVal("add_pc", ID_EX_PC, 32'h104);

    // Load to $0 must never stall a reader of $0.
    ID_MemRd = 1; ID_RegDst = 5'd0; IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd1; ID_PC = 32'h108;
    stepCycle("load_r0");
    ID_MemRd = 0; IF_ID_Rs = 5'd0; ID_UsesRs = 1; ID_RegDst = 5'd4; ID_PC = 32'h10C;
    #1 expectVal("r0_no_stall", 32'(Stall), 32'd0);
    stepCycle("r0_reader");
    expectVal("r0_reader_pc", ID_EX_PC, 32'h10C);

    // Match only on Rt while Rt is unused: no hazard.
    ID_MemRd = 1; ID_RegDst = 5'd7; IF_ID_Rs = 5'd1; ID_UsesRt = 0; ID_PC = 32'h110;
    stepCycle("load_r7");
    ID_MemRd = 0; IF_ID_Rt = 5'd7; ID_UsesRs = 1; ID_RegDst = 5'd5; ID_PC = 32'h114;
    #1 expectVal("rt_unused_no_stall", 32'(Stall), 32'd0);
    stepCycle("rt_unused_capture");
    expectVal("rt_unused_count", 32'(StallCount), 32'd1);

    // Flush arriving together with a hazard: bubble, no stall, no count.
    ID_MemRd = 1; ID_RegDst = 5'd10; IF_ID_Rs = 5'd1; ID_PC = 32'h118;
    stepCycle("load_r10");
    ID_MemRd = 0; IF_ID_Rs = 5'd10; ID_UsesRs = 1; ID_RegDst = 5'd6; ID_PC = 32'h11C; Flush = 1;
    #1 expectVal("flush_lu_stall", 32'(Stall), 32'd0);
    stepCycle("flush_lu_bubble");
    expectVal("flush_valid", 32'(ID_EX_Valid), 32'd0);
    expectVal("flush_count", 32'(StallCount), 32'd1);
    Flush = 0;

    // Hold with Flush for three cycles freezes everything.
    IF_ID_Rs = 5'd1; ID_PC = 32'h120;
    stepCycle("pre_hold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      Hold = 1; Flush = 1;
      stepCycle("hold_flush");
      expectVal("hold_pc", ID_EX_PC, 32'h120);
      expectVal("hold_count", 32'(StallCount), 32'd1);
    end
    clearInputs();
    ID_Valid = 1; ID_PC = 32'h124;

    // Write-through of WB data into BusA, and its suppression for $0.
    MEM_WB_RegWr = 1; MEM_WB_RegDst = 5'd5; WB_Data = 32'hDEADBEEF;
    IF_ID_Rs = 5'd5; ID_UsesRs = 1; ID_BusA = 32'h1;
    stepCycle("wt_hit");
    expectVal("wt_busa", ID_EX_BusA, 32'hDEADBEEF);
    MEM_WB_RegDst = 5'd0; IF_ID_Rs = 5'd0;
    stepCycle("wt_r0");
    expectVal("wt_r0_busa", ID_EX_BusA, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle("random");
    end

    // Make sure there is state to clear, then reset mid-cycle.
    clearInputs();
    ID_Valid = 1; ID_RegWr = 1; ID_PC = 32'hCAFE0000; ID_RegDst = 5'd3;
    stepCycle("pre_reset");
    #2 reset = 0;
    m = '0;
    mCount = '0;
    #1 checkOutput("async_reset");
    @(posedge clk);
    #1 checkOutput("reset_held");
    @(negedge clk);
    reset = 1;
    ID_PC = 32'h400;
    stepCycle("post_reset");
    expectVal("post_reset_pc", ID_EX_PC, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
